// File: rtl/peripheral_dbg_soc_dii_arbiter_pkg.sv
// Shared DII channel types: flit layout, arbiter state encoding and flit builder.
package peripheral_dbg_soc_dii_channel;

  localparam int DII_FLIT_WIDTH = 18;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } dii_arb_state;

  function automatic dii_flit dii_flit_assemble(input logic valid, input logic last,
                                                input logic [15:0] data);
    dii_flit f;
    f.valid = valid;
    f.last  = last;
    f.data  = data;
    return f;
  endfunction

endpackage

// File: rtl/peripheral_dbg_soc_dii_arbiter_if.sv
// DII arbiter bus bundle: PORTS flattened source flits with per-port ready, one sink flit.
interface peripheral_dbg_soc_dii_arbiter_if
  import peripheral_dbg_soc_dii_channel::*;
#(
  parameter int PORTS = 2
);

  logic [PORTS*DII_FLIT_WIDTH-1:0] in_flit;
  logic [PORTS-1:0]                in_ready;
  dii_flit                         out_flit;
  logic                            out_ready;

  modport master (
    output in_flit,
    input  in_ready,
    input  out_flit,
    output out_ready
  );

  modport slave (
    input  in_flit,
    output in_ready,
    output out_flit,
    input  out_ready
  );

endinterface

// File: rtl/peripheral_dbg_soc_rr_select.sv
// Combinational cyclic priority encoder: first requester after ptr, wrapping modulo N.
module peripheral_dbg_soc_rr_select #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  // Scan ptr+1 .. ptr+N; the first hit latches and masks all later candidates
  always_comb begin
    int   idx;
    logic hit;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    hit        = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx             = (int'(ptr) + off) % N;
      hit             = !any && req[idx];
      gnt_onehot[idx] = gnt_onehot[idx] | hit;
      gnt_idx         = hit ? PW'(idx) : gnt_idx;
      any             = any | hit;
    end
  end

endmodule

// File: rtl/peripheral_dbg_soc_dii_arbiter.sv
// Packet-atomic round-robin DII arbiter: merges PORTS sources onto one sink through a
// single registered output stage; a granted packet runs to its last flit uninterrupted.
module peripheral_dbg_soc_dii_arbiter
  import peripheral_dbg_soc_dii_channel::*;
#(
  parameter int PORTS = 2
) (
  input logic                              clk,
  input logic                              rst,
  peripheral_dbg_soc_dii_arbiter_if.slave  dii
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  dii_arb_state     r_state;
  dii_arb_state     w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    r_grant;
  logic [PW-1:0]    w_grant_nxt;
  logic [PW-1:0]    w_win_idx;
  logic [PW-1:0]    w_sel_idx;
  logic [PORTS-1:0] w_req;
  logic [PORTS-1:0] w_win_onehot;
  logic [PORTS-1:0] w_ready;
  logic             w_any;
  logic             w_space;
  logic             w_xfer;
  dii_flit          w_sel_flit;
  dii_flit          r_out;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      w_req[i] = dii.in_flit[DII_FLIT_WIDTH*i + DII_FLIT_WIDTH - 1];
    end
  end

  peripheral_dbg_soc_rr_select #(
    .N (PORTS)
  ) u_rr_select (
    .req        (w_req),
    .ptr        (r_ptr),
    .gnt_onehot (w_win_onehot),
    .gnt_idx    (w_win_idx),
    .any        (w_any)
  );

  // Ready only looks at the output register's valid bit, never its payload
  assign w_space = !r_out.valid || dii.out_ready;

  // Next-state, grant/pointer update and ready fan-out
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_sel_idx   = r_grant;
    w_ready     = '0;
    w_xfer      = 1'b0;
    w_sel_flit  = '0;

    case (r_state)
      ARB_IDLE: begin
        w_sel_idx = w_win_idx;
        if (w_any) begin
          w_ready = w_win_onehot & {PORTS{w_space}};
        end else begin
          w_ready = '0;
        end
      end
      ARB_LOCKED: begin
        w_sel_idx          = r_grant;
        w_ready[r_grant]   = w_space;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase

    if (rst) begin
      w_ready = '0;
    end else begin
      w_ready = w_ready;
    end

    w_sel_flit = dii_flit'(dii.in_flit[DII_FLIT_WIDTH*w_sel_idx +: DII_FLIT_WIDTH]);
    w_xfer     = |(w_ready & w_req);

    if (w_xfer && w_sel_flit.last) begin
      w_state_nxt = ARB_IDLE;
      w_ptr_nxt   = w_sel_idx;
    end else if (w_xfer && (r_state == ARB_IDLE)) begin
      w_state_nxt = ARB_LOCKED;
      w_grant_nxt = w_win_idx;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Arbitration state; reset leaves port 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= PW'(PORTS - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Output pipeline stage; reset discards any flit in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_xfer) begin
      r_out <= dii_flit_assemble(1'b1, w_sel_flit.last, w_sel_flit.data);
    end else if (dii.out_ready) begin
      r_out.valid <= 1'b0;
    end else begin
      r_out <= r_out;
    end
  end

  assign dii.out_flit = r_out;
  assign dii.in_ready = w_ready;

endmodule
